// File: rtl/fifo_operand_reader_if.sv
// Handshake/bus bundle between the operand FIFO, the reader and the consumer.
//   en, clear        : read permission and synchronous discard (from control)
//   fifo_empty/dout  : upstream FIFO status and read data (data valid the cycle after a read)
//   fifo_rd_en       : FIFO read request (from reader)
//   op_data/op_valid : assembled operand and its valid flag (from reader)
//   op_ready         : consumer accept
//   word_cnt         : words captured into the current operand (from reader)
interface fifo_operand_reader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OP_WIDTH   = 512
);
  localparam int unsigned WORDS = OP_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(WORDS) + 1;

  logic                  en;
  logic                  clear;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic [OP_WIDTH-1:0]   op_data;
  logic                  op_valid;
  logic                  op_ready;
  logic [CNT_W-1:0]      word_cnt;

  // Environment side: drives control, FIFO status/data and consumer accept.
  modport master (
    output en, clear, fifo_empty, fifo_dout, op_ready,
    input  fifo_rd_en, op_data, op_valid, word_cnt
  );

  // Reader side.
  modport slave (
    input  en, clear, fifo_empty, fifo_dout, op_ready,
    output fifo_rd_en, op_data, op_valid, word_cnt
  );
endinterface

// File: rtl/fifo_operand_reader.sv
// Reads DATA_WIDTH words from an operand FIFO and assembles them into one
// OP_WIDTH operand (word 0 in the low bits), holding it until the consumer
// accepts it.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fifo_operand_reader_if.slave (control, FIFO side, operand side)
module fifo_operand_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OP_WIDTH   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_operand_reader_if.slave  bus
);
  localparam int unsigned WORDS = OP_WIDTH / DATA_WIDTH;
  localparam int unsigned CW    = $clog2(WORDS) + 1;

  if (OP_WIDTH % DATA_WIDTH != 0) begin : g_bad_width
    $error("OP_WIDTH must be an integer multiple of DATA_WIDTH");
  end

  typedef enum logic {ST_FETCH = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       issued_q, issued_d;
  logic [CW-1:0]       word_cnt_q, word_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [OP_WIDTH-1:0] op_data_q, op_data_d;
  logic                op_valid_q, op_valid_d;
  logic                rd_en_c;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      issued_q   <= '0;
      word_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      op_data_q  <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      word_cnt_q <= word_cnt_d;
      rd_pend_q  <= rd_pend_d;
      op_data_q  <= op_data_d;
      op_valid_q <= op_valid_d;
    end
  end

  // Read request, capture, handshake and clear; later assignments take priority.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    word_cnt_d = word_cnt_q;
    op_data_d  = op_data_q;
    op_valid_d = op_valid_q;

    // rst gates the request so the FIFO sees no read while reset is held.
    rd_en_c = (state_q == ST_FETCH) && bus.en && !bus.fifo_empty && !bus.clear &&
              (issued_q < CW'(WORDS)) && !rst;
    rd_pend_d = rd_en_c;

    if (rd_en_c) begin
      issued_d = issued_q + CW'(1);
    end

    // Word read last cycle is on fifo_dout now; drop it into the next slot.
    if (rd_pend_q && (word_cnt_q < CW'(WORDS))) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        if (word_cnt_q == CW'(i)) begin
          op_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_dout;
        end
      end
      word_cnt_d = word_cnt_q + CW'(1);
      if (word_cnt_q == CW'(WORDS - 1)) begin
        state_d    = ST_HOLD;
        op_valid_d = 1'b1;
      end
    end

    // Consumer accepts the held operand; next read waits for the following cycle.
    if ((state_q == ST_HOLD) && op_valid_q && bus.op_ready) begin
      state_d    = ST_FETCH;
      op_valid_d = 1'b0;
      word_cnt_d = '0;
      issued_d   = '0;
    end

    // Discard wins over capture and handshake; op_data is left as is.
    if (bus.clear) begin
      state_d    = ST_FETCH;
      op_valid_d = 1'b0;
      word_cnt_d = '0;
      issued_d   = '0;
      rd_pend_d  = 1'b0;
    end
  end

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.op_data    = op_data_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.word_cnt   = word_cnt_q;
endmodule

// File: doc/fifo_operand_reader.md
FIFO_OPERAND_READER -- requirements
Module: fifo_operand_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the FIFO word width in bits.
REQ-002 Parameter OP_WIDTH, default 512, is the assembled operand width in bits; WORDS = OP_WIDTH/DATA_WIDTH (default 32); OP_WIDTH SHALL be an integer multiple of DATA_WIDTH.
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, is the asynchronous, active-high reset.
REQ-005 Port en, input, 1 bit, SHALL permit new FIFO reads while high.
REQ-006 Port clear, input, 1 bit, is a synchronous discard of any partial or held operand.
REQ-007 Port fifo_empty, input, 1 bit, is the empty flag of the upstream 16x64 operand FIFO.
REQ-008 Port fifo_dout, input, DATA_WIDTH bits, is the FIFO read data, valid the cycle after an accepted read.
REQ-009 Port fifo_rd_en, output, 1 bit, is the FIFO read request.
REQ-010 Port op_data, output, OP_WIDTH bits, is the assembled operand, word 0 in bits [DATA_WIDTH-1:0].
REQ-011 Port op_valid, output, 1 bit, SHALL indicate that op_data holds a complete operand.
REQ-012 Port op_ready, input, 1 bit, is the consumer (modexp unit) accept signal.
REQ-013 Port word_cnt, output, clog2(WORDS)+1 bits, is the number of words captured into the current operand.

Function
REQ-014 The block SHALL have two states: FETCH and HOLD.
REQ-015 In FETCH, fifo_rd_en SHALL be combinationally high iff en=1, fifo_empty=0, clear=0 and issued < WORDS, where issued is the count of reads issued for the current operand.
REQ-016 A registered flag rd_pend SHALL be set on every edge where fifo_rd_en=1 and cleared otherwise.
REQ-017 On an edge where rd_pend=1, fifo_dout SHALL be captured into slot word_cnt of op_data, and word_cnt SHALL increment.
REQ-018 Reads SHALL sustain one word per cycle while the FIFO is non-empty: first read in cycle 0 gives reads in cycles 0-31, captures at the ends of cycles 1-32, and op_valid=1 from cycle 33.
REQ-019 The capture that makes word_cnt reach WORDS SHALL move the block to HOLD and set op_valid at the same edge.
REQ-020 In HOLD, fifo_rd_en SHALL be 0, and op_data and op_valid SHALL remain stable until op_valid=1 and op_ready=1 at an edge.
REQ-021 On the handshake edge, op_valid, word_cnt and issued SHALL clear, and the state SHALL return to FETCH.
REQ-022 The first read of the next operand SHALL be permitted in the cycle after the handshake edge; there SHALL be no back-to-back reuse within the handshake cycle.
REQ-023 If en drops mid-operand, no new reads SHALL be issued, an outstanding rd_pend capture SHALL still complete, and the partial operand SHALL be retained and resumed when en returns.
REQ-024 If fifo_empty rises mid-operand, reads SHALL pause with no bubble words captured, and assembly SHALL resume when fifo_empty falls.
REQ-025 The word count SHALL never exceed WORDS, and issued SHALL never exceed WORDS.
REQ-026 On clear=1, the block SHALL return to FETCH with op_valid, word_cnt, issued and rd_pend zeroed; any in-flight FIFO word SHALL be dropped; op_data contents need not be zeroed.
REQ-027 clear SHALL take priority over capture and over the handshake in the same cycle.
REQ-028 op_ready SHALL be ignored while op_valid=0.

Reset
REQ-029 On rst=1, the block SHALL immediately enter FETCH with op_valid=0, word_cnt=0, issued=0, rd_pend=0 and op_data=0, and fifo_rd_en SHALL be forced to 0.
REQ-030 A reset asserted mid-operand or in HOLD SHALL discard the operand with no capture on the following edges.
REQ-031 The first read after deassertion SHALL occur no earlier than the first clock edge after rst falls.

Verification
REQ-032 FIFO preloaded with 0x0001..0x0020, en=1, op_ready=1 -> reads in cycles 0-31; op_valid in cycle 33 with op_data[15:0]=0x0001 and op_data[511:496]=0x0020; then FETCH resumes.
REQ-033 Same preload, op_ready=0 for 10 cycles after op_valid -> op_data stable, fifo_rd_en=0 throughout HOLD; release -> op_valid=0 the next cycle.
REQ-034 Only 20 words available, with 12 more written 15 cycles later -> word_cnt stalls at 20 with no rd_en while empty; the operand completes with the correct word order.
REQ-035 en dropped after 5 reads, restored 8 cycles later -> word_cnt=5 held; no extra or lost words; the final operand is correct.
REQ-036 clear pulsed in the cycle rd_pend=1 at word 10 -> word_cnt=0, op_valid=0; the next operand starts at the following FIFO word.
REQ-037 rst asserted in HOLD -> op_valid, word_cnt and fifo_rd_en are 0 immediately; no capture occurs after release until a new read.
